// File: rtl/ak16_pkg.sv
// Definitions shared by the AK-16 boot loader, the CPU and their benches:
// loader FSM states, frame marker default, instruction width and HALT opcode.
package ak16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int          INSTR_W       = 16;
  localparam logic [15:0] HALT_OP       = 16'h0F00;

endpackage

// File: rtl/cpu_prog_loader.sv
// Boot loader: frames a byte stream into big-endian 16-bit words written to imem from address 0,
// holding the CPU in reset until the frame completes. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module cpu_prog_loader
  import ak16_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst_hold,
  output logic               done,
  output logic               err
);

  loader_state_t     state;
  logic [7:0]        n_len;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  logic xfer;
  logic last_word;

  assign xfer      = in_valid & in_ready;
  assign last_word = (count == ADDR_W'(n_len - 8'd1));

  // NOTE: every register here uses <= so all of them see the pre-edge values of
  // state/count/hi_byte; blocking assignments would let later lines see updated values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst_hold <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      n_len        <= '0;
      hi_byte      <= '0;
      count        <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse; ready is withdrawn only on entry to DONE.
      imem_we  <= 1'b0;
      in_ready <= 1'b1;

      if (start && state != ST_IDLE) begin
        state        <= ST_IDLE;
        done         <= 1'b0;
        cpu_rst_hold <= 1'b1;
        err          <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (xfer && in_data == SYNC_BYTE) state <= ST_LEN;
          end

          ST_LEN: begin
            if (xfer) begin
              if (in_data == 8'd0) begin
                state <= ST_ERR;
                err   <= 1'b1;
              end else begin
                n_len <= in_data;
                count <= '0;
`ifdef LOADER_CHECKSUM_EN
                chk   <= '0;
`endif
                state <= ST_DATA_HI;
              end
            end
          end

          ST_DATA_HI: begin
            if (xfer) begin
              hi_byte <= in_data;
`ifdef LOADER_CHECKSUM_EN
              chk     <= chk ^ in_data;
`endif
              state   <= ST_DATA_LO;
            end
          end

          ST_DATA_LO: begin
            if (xfer) begin
              imem_we    <= 1'b1;
              imem_addr  <= count;
              imem_wdata <= {hi_byte, in_data};
              count      <= count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
              chk        <= chk ^ in_data;
              state      <= last_word ? ST_CHK : ST_DATA_HI;
`else
              if (last_word) begin
                state    <= ST_DONE;
                in_ready <= 1'b0;
              end else begin
                state    <= ST_DATA_HI;
              end
`endif
            end
          end

`ifdef LOADER_CHECKSUM_EN
          ST_CHK: begin
            if (xfer) begin
              if (in_data == chk) begin
                state    <= ST_DONE;
                in_ready <= 1'b0;
              end else begin
                state    <= ST_ERR;
                err      <= 1'b1;
              end
            end
          end
`endif

          ST_DONE: begin
            // Status flags follow one cycle after entry; leaving DONE needs start.
            in_ready     <= 1'b0;
            done         <= 1'b1;
            cpu_rst_hold <= 1'b0;
          end

          ST_ERR: begin
            if (xfer && in_data == SYNC_BYTE) begin
              state <= ST_LEN;
              err   <= 1'b0;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: expected writes come from the frames sent, checked every cycle,
// plus hand-computed status/memory expectations. Honours LOADER_CHECKSUM_EN like the RTL.
module tb_cpu_prog_loader;
  import ak16_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst_hold;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  cpu_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_hold (cpu_rst_hold),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         cur;
  logic [15:0] mem [256];
  logic [15:0] prog[$];
  bit          bubbles = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the next word the frames promised.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
        end else begin
          cur = exp_q.pop_front();
          check("wr_addr", imem_addr, cur.addr);
          check("wr_data", imem_wdata, cur.data);
          mem[imem_addr] = imem_wdata;
        end
      end
      if (done) check("done_releases_cpu", {in_ready, cpu_rst_hold}, 2'b00);
      if (err)  check("err_holds_cpu", {cpu_rst_hold, done}, 2'b10);
    end
  end

  function automatic logic [7:0] frame_chk(input logic [15:0] w[$]);
    logic [7:0] x = 8'h00;
    foreach (w[i]) x = x ^ w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (bubbles && $urandom_range(1) == 1) tick(1);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 40) begin
      tick(1);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h expected 1", b);
      in_valid = 1'b0;
      return;
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w[$], input int chk_override);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c = frame_chk(w);
`endif
    foreach (w[i]) exp_q.push_back(wr_t'{addr: 8'(i), data: w[i]});
    send_byte(8'hA5);
    send_byte(8'(w.size()));
    foreach (w[i]) begin
      send_byte(w[i][15:8]);
      send_byte(w[i][7:0]);
      check("write_latency", imem_we, 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk_override < 0 ? c : 8'(chk_override));
`else
    if (chk_override >= 0) $display("note: checksum byte %0h not sent in this build", chk_override);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic expect_loaded(input string tag);
    check({tag, "_done_early"}, done, 1'b0);
    tick(1);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_hold"}, cpu_rst_hold, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_hold", cpu_rst_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_wdata", imem_wdata, 16'h0000);
    tick(2);
    rst = 1'b0;
    check("ready_after_rst", in_ready, 1'b0);
    tick(1);
    check("ready_idle", in_ready, 1'b1);

    // Good frame: A5 02 12 34 F0 00 [D6]
    prog = '{16'h1234, 16'hF000};
    check("model_chk_pin", frame_chk(prog), 8'hD6);
    send_frame(prog, -1);
    expect_loaded("good");
    check("mem0_pin", mem[0], 16'h1234);
    check("mem1_pin", mem[1], 16'hF000);

    // DONE ignores offered bytes
    in_valid = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("done_backpressure", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    pulse_start();
    check("rearm_done", done, 1'b0);
    check("rearm_hold", cpu_rst_hold, 1'b1);
    check("rearm_ready", in_ready, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: A5 01 AB CD 00 -- word still written, then rejected
    prog = '{16'hABCD};
    check("model_chk_bad_pin", frame_chk(prog), 8'h66);
    send_frame(prog, 8'h00);
    check("badchk_err", err, 1'b1);
    tick(1);
    check("badchk_err_sticky", err, 1'b1);
    check("badchk_hold", cpu_rst_hold, 1'b1);
    check("badchk_done", done, 1'b0);
    check("badchk_mem0", mem[0], 16'hABCD);
    prog = '{16'h0001};
    send_frame(prog, -1);
    expect_loaded("recover");
    pulse_start();
`endif

    // Garbage then zero length
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    check("len0_not_err_yet", err, 1'b0);
    send_byte(8'h00);
    check("len0_err", err, 1'b1);
    check("len0_hold", cpu_rst_hold, 1'b1);
    check("len0_ready", in_ready, 1'b1);
    check("len0_no_writes", exp_q.size(), 0);
    pulse_start();
    check("start_clears_err", err, 1'b0);

    // Bubbles: same frame plus a HALT-terminated program
    bubbles = 1'b1;
    prog = '{16'h1234, 16'hF000};
    send_frame(prog, -1);
    expect_loaded("bubble");
    pulse_start();
    prog = '{16'h1111, 16'h2222, HALT_OP};
    send_frame(prog, -1);
    expect_loaded("halt_prog");
    check("halt_last_word", mem[2], 16'h0F00);
    bubbles = 1'b0;
    pulse_start();

    // Abort after A5 03 11 22 33
    exp_q.push_back(wr_t'{addr: 8'h00, data: 16'h1122});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    pulse_start();
    check("abort_ready", in_ready, 1'b1);
    check("abort_hold", cpu_rst_hold, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_mem0", mem[0], 16'h1122);
    check("abort_mem1_kept", mem[1], 16'h2222);
    check("abort_pending", exp_q.size(), 0);
    send_byte(8'h33);
    prog = '{16'hBEEF};
    send_frame(prog, -1);
    expect_loaded("after_abort");
    pulse_start();

    // Async reset while a low byte is being offered in DATA_LO
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    in_valid = 1'b1; in_data = 8'h34;
    #2 rst = 1'b1;
    #1;
    check("arst_ready", in_ready, 1'b0);
    check("arst_hold", cpu_rst_hold, 1'b1);
    check("arst_we", imem_we, 1'b0);
    check("arst_addr", imem_addr, 8'h00);
    check("arst_wdata", imem_wdata, 16'h0000);
    tick(1);
    in_valid = 1'b0;
    rst = 1'b0;
    tick(1);
    check("arst_ready_back", in_ready, 1'b1);
    prog = '{16'hCAFE};
    send_frame(prog, -1);
    expect_loaded("after_rst");
    check("mem0_after_rst", mem[0], 16'hCAFE);

    tick(3);
    check("all_writes_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
